weight_sram_stream: RTL and testbench
=====================================

Name: weight_sram_stream

Overview:
Parametrised successor of the byte-addressed weight SRAM.
- Byte-addressed storage, written through a multi-lane port with per-byte write enables.
- Built-in burst read engine streams LANES-byte words at base + k*stride to the PE array.
- Output uses a valid/ready handshake, so the convolution datapath can apply backpressure without re-issuing addresses.

Parameters:
- ADDR_W, 16: byte address width; memory depth is 2^ADDR_W bytes.
- LANES, 4: bytes per word on the write and read ports; data width is 8*LANES.
- LEN_W, 8: width of the burst length field; maximum burst is 2^LEN_W-1 words.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- wen  in  1  write strobe
- waddr  in  ADDR_W  byte address of write lane 0
- wdata  in  8*LANES  write data; lane i = wdata[8i+7:8i]
- wbe  in  LANES  per-lane byte enable
- start  in  1  burst request, sampled in IDLE only
- base_addr  in  ADDR_W  byte address of word 0
- stride  in  ADDR_W  byte increment between words
- len  in  LEN_W  number of words in the burst
- busy  out  1  high while a burst is in progress
- done  out  1  one-cycle pulse on final handshake
- q_valid  out  1  q holds a valid word
- q_ready  in  1  consumer accepts q
- q  out  8*LANES  read word {ram[a+LANES-1],...,ram[a]}
- q_last  out  1  q is the final word of the burst

Behaviour:
- Reset (async, rst=1): busy=0, done=0, q_valid=0, q_last=0, q=0, word counter=0, FSM=IDLE. Memory contents are not cleared.
- Write: at a clk edge with wen=1, for each i with wbe[i]=1, ram[(waddr+i) mod 2^ADDR_W] <= lane i. Writes are accepted in any FSM state.
- All address arithmetic is modulo 2^ADDR_W. Byte addresses within a word wrap as well (a+LANES-1 past the top wraps to 0).
- FSM states: IDLE, RUN.
- IDLE, start=1, len!=0: latch base_addr, stride and len. Next state RUN, busy=1 from the next cycle.
- IDLE, start=1, len=0: stay IDLE. done pulses 1 cycle later. q_valid is never asserted.
- start while busy is ignored; the latched parameters do not change.
- RUN: internal word address a_k = base + k*stride, k = 0..len-1, held in an accumulating address register (no multiplier).
- The output register loads word k when (q_valid==0 || q_ready==1) and words remain. The load samples memory contents before any same-edge write (read-before-write).
- First word: q_valid=1 in the cycle after the start edge. Latency 1.
- With q_ready held high, one word per cycle; a len-word burst completes len cycles after start.
- q_valid=1 && q_ready=0: q, q_last and q_valid hold stable. The address does not advance.
- q_last=1 exactly when q holds word len-1.
- Final handshake (q_valid && q_ready && q_last): next cycle q_valid=0, busy=0, done=1 for one cycle, state IDLE.
- A new start is accepted in the same cycle done is high.
- q keeps its last value when q_valid=0.
- Writes during RUN to addresses not yet loaded are visible in later words (the read engine sees current memory).
- Reset asserted mid-burst aborts immediately. No done pulse; the remaining words are discarded.
- stride=0 is legal: the same word is returned len times.

Test Plan:
- Preload: write bytes 0x01..0x08 at addr 0x0010 with wbe=4'hF (two writes). Burst base=0x0010, stride=4, len=2, q_ready=1 -> q=0x04030201 then 0x08070605, q_last on the second word, done 1 cycle after it, busy low after.
- Byte enable: write 0xAABBCCDD at 0x0020 with wbe=4'hF, then 0x11223344 with wbe=4'b0101. Burst len=1 -> q=0xAA22CC44.
- Wrap-around: write 0xDEADBEEF at 0xFFFE (lanes wrap to 0x0000/0x0001). Burst base=0xFFFE, len=1 -> q=0xDEADBEEF. Burst base=0xFFF0, stride=0x0008, len=3 -> words from 0xFFF0, 0xFFF8, 0x0000.
- Backpressure: len=4, q_ready toggled 1,0,0,1,1,0,1 -> each word appears exactly once, q stable while stalled, q_last only on word 3, done once.
- Edge controls: start with len=0 -> done pulse only, no q_valid. start while busy -> ignored, original burst completes unchanged.
- Reset and collision: rst pulsed mid-burst (after word 1 accepted) -> all outputs 0 asynchronously, no done; a fresh burst then works. Write to word k's address in the edge word k loads -> q shows old data.

Source files
------------

// File: rtl/weight_sram_stream.sv
// Byte-addressed weight SRAM with a multi-lane byte-enable write port and a
// strided burst read engine that streams words over a valid/ready handshake.
`timescale 1ns/1ps

module weight_sram_stream #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 4,
  parameter int LEN_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wen_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [8*LANES-1:0]   wdata_i,
  input  logic [LANES-1:0]     wbe_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W-1:0]    stride_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 q_valid_o,
  input  logic                 q_ready_i,
  output logic [8*LANES-1:0]   q_o,
  output logic                 q_last_o
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = 8 * LANES;

  typedef enum logic {IDLE, RUN} state_t;

  logic [7:0]        mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              qValid_q, qValid_d;
  logic              qLast_q, qLast_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdWord;
  logic              handshake;
  logic              wordsLeft;

  // Storage has no reset; per-lane byte addresses wrap at the top of memory.
  always_ff @(posedge clk_i) begin
    if (wen_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe_i[i]) begin
          mem[waddr_i + ADDR_W'(i)] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdAddr = (state_q == IDLE) ? base_addr_i : addr_q;
    rdWord = '0;
    for (int i = 0; i < LANES; i++) begin
      rdWord[8*i +: 8] = mem[rdAddr + ADDR_W'(i)];
    end
  end

  assign handshake = qValid_q && q_ready_i;
  assign wordsLeft = (cnt_q != len_q);

  // addr_q always points at the next word to load, so word 0 is read straight
  // from base_addr_i on the start edge to give single-cycle latency.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    qValid_d = qValid_q;
    qLast_d  = qLast_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            stride_d = stride_i;
            len_d    = len_i;
            addr_d   = base_addr_i + stride_i;
            cnt_d    = LEN_W'(1);
            q_d      = rdWord;
            qValid_d = 1'b1;
            qLast_d  = (len_i == LEN_W'(1));
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (handshake && qLast_q) begin
          qValid_d = 1'b0;
          qLast_d  = 1'b0;
          cnt_d    = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if ((!qValid_q || q_ready_i) && wordsLeft) begin
          q_d      = rdWord;
          qValid_d = 1'b1;
          qLast_d  = (cnt_q == len_q - LEN_W'(1));
          addr_d   = addr_q + stride_q;
          cnt_d    = cnt_q + LEN_W'(1);
        end else if (handshake) begin
          qValid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      qValid_q <= 1'b0;
      qLast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qValid_q <= qValid_d;
      qLast_q  <= qLast_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;
  assign q_valid_o = qValid_q;
  assign q_o       = q_q;
  assign q_last_o  = qLast_q;

endmodule

// File: tb/tb_weight_sram_stream.sv
// Self-checking bench for weight_sram_stream: constant vector table, hand
// sequences for multi-cycle corners, and random bursts against a byte-array model.
`timescale 1ns/1ps

module tb_weight_sram_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] stride;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        q_valid;
  logic        q_ready;
  logic [31:0] q;
  logic        q_last;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0] refMem [65536];

  typedef struct {
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [15:0] rbase;
    logic [31:0] expQ;
  } vec_t;

  vec_t vecs [7];

  weight_sram_stream #(.ADDR_W(16), .LANES(4), .LEN_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wen_i       (wen),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .wbe_i       (wbe),
    .start_i     (start),
    .base_addr_i (base_addr),
    .stride_i    (stride),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .q_valid_o   (q_valid),
    .q_ready_i   (q_ready),
    .q_o         (q),
    .q_last_o    (q_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] refWord(input logic [15:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = refMem[a + 16'(i)];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic st, input logic [15:0] b,
                               input logic [15:0] s, input logic [7:0] l, input logic rdy);
    wen = w; waddr = wa; wdata = wd; wbe = be;
    start = st; base_addr = b; stride = s; len = l;
    q_ready = rdy;
    tick();
    if (w) begin
      for (int i = 0; i < 4; i++) if (be[i]) refMem[wa + 16'(i)] = wd[8*i +: 8];
    end
    wen = 1'b0;
    start = 1'b0;
  endtask

  task automatic writeWord(input logic [15:0] wa, input logic [31:0] wd, input logic [3:0] be);
    applyStimulus(1'b1, wa, wd, be, 1'b0, 16'h0, 16'h0, 8'h0, 1'b1);
  endtask

  // Expected words come from the model as base + k*stride (mod 2^16).
  task automatic runBurst(input logic [15:0] b, input logic [15:0] s, input int l,
                          input bit randReady, input logic [31:0] pat, input int patLen,
                          input bit pokeStart);
    logic [31:0] expq [$];
    logic [31:0] holdQ;
    logic        holdLast;
    logic        rdy;
    bit          stalled;
    int          idx;
    for (int k = 0; k < l; k++) expq.push_back(refWord(16'(32'(b) + k * 32'(s))));
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, b, s, 8'(l), 1'b1);
    if (l == 0) begin
      checkOutput("len0 done", 32'(done), 32'd1);
      checkOutput("len0 valid", 32'(q_valid), 32'd0);
      checkOutput("len0 busy", 32'(busy), 32'd0);
      tick();
      checkOutput("len0 done drop", 32'(done), 32'd0);
      checkOutput("len0 valid later", 32'(q_valid), 32'd0);
      return;
    end
    checkOutput("first valid", 32'(q_valid), 32'd1);
    checkOutput("busy", 32'(busy), 32'd1);
    idx = 0;
    stalled = 1'b0;
    holdQ = '0;
    holdLast = 1'b0;
    for (int cyc = 0; cyc < 200 && idx < l; cyc++) begin
      if (randReady) rdy = 1'($urandom_range(0, 1));
      else rdy = (cyc < patLen) ? pat[cyc] : 1'b1;
      q_ready = rdy;
      if (pokeStart && cyc == 0) begin
        start = 1'b1; base_addr = b + 16'h40; stride = s + 16'h1; len = 8'(l + 1);
      end
      if (stalled) begin
        checkOutput("stall q", q, holdQ);
        checkOutput("stall last", 32'(q_last), 32'(holdLast));
        checkOutput("stall valid", 32'(q_valid), 32'd1);
      end
      checkOutput("no early done", 32'(done), 32'd0);
      if (q_valid && rdy) begin
        checkOutput("word", q, expq[idx]);
        checkOutput("last flag", 32'(q_last), 32'(idx == l - 1));
        idx++;
      end
      stalled = q_valid && !rdy;
      holdQ = q;
      holdLast = q_last;
      tick();
      start = 1'b0;
    end
    checkOutput("burst word count", 32'(idx), 32'(l));
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("busy after", 32'(busy), 32'd0);
    checkOutput("valid after", 32'(q_valid), 32'd0);
    tick();
    checkOutput("done once", 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 32'h04030201, 4'hF, 16'h0010, 32'h04030201};
    vecs[1] = '{16'h0014, 32'h08070605, 4'hF, 16'h0014, 32'h08070605};
    vecs[2] = '{16'h0020, 32'hAABBCCDD, 4'hF, 16'h0020, 32'hAABBCCDD};
    vecs[3] = '{16'h0020, 32'h11223344, 4'h5, 16'h0020, 32'hAA22CC44};
    vecs[4] = '{16'hFFFE, 32'hDEADBEEF, 4'hF, 16'hFFFE, 32'hDEADBEEF};
    vecs[5] = '{16'h0100, 32'h12345678, 4'hF, 16'h0100, 32'h12345678};
    vecs[6] = '{16'h0102, 32'hFFEEDDCC, 4'h3, 16'h0100, 32'hDDCC5678};

    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    start = 1'b0; base_addr = '0; stride = '0; len = '0; q_ready = 1'b0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset valid", 32'(q_valid), 32'd0);
    checkOutput("reset last", 32'(q_last), 32'd0);
    checkOutput("reset q", q, 32'h0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      writeWord(vecs[v].waddr, vecs[v].wdata, vecs[v].wbe);
      applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, vecs[v].rbase, 16'h4, 8'd1, 1'b1);
      checkOutput("vec q", q, vecs[v].expQ);
      checkOutput("vec valid", 32'(q_valid), 32'd1);
      checkOutput("vec last", 32'(q_last), 32'd1);
      tick();
      checkOutput("vec done", 32'(done), 32'd1);
      checkOutput("vec valid drop", 32'(q_valid), 32'd0);
    end

    // Two-word preload burst, then a new start accepted while done is high.
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0010, 16'h4, 8'd2, 1'b1);
    checkOutput("pre w0", q, 32'h04030201);
    checkOutput("pre w0 last", 32'(q_last), 32'd0);
    checkOutput("pre busy", 32'(busy), 32'd1);
    tick();
    checkOutput("pre w1", q, 32'h08070605);
    checkOutput("pre w1 last", 32'(q_last), 32'd1);
    tick();
    checkOutput("pre done", 32'(done), 32'd1);
    checkOutput("pre busy low", 32'(busy), 32'd0);
    checkOutput("pre valid low", 32'(q_valid), 32'd0);
    checkOutput("q held idle", q, 32'h08070605);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0014, 16'h4, 8'd1, 1'b1);
    checkOutput("b2b valid", 32'(q_valid), 32'd1);
    checkOutput("b2b q", q, 32'h08070605);
    checkOutput("b2b done drop", 32'(done), 32'd0);
    tick();
    checkOutput("b2b done", 32'(done), 32'd1);

    // Wrap-around stride burst.
    writeWord(16'hFFF0, 32'hC0C1C2C3, 4'hF);
    writeWord(16'hFFF8, 32'hD0D1D2D3, 4'hF);
    writeWord(16'h0000, 32'hE0E1E2E3, 4'hF);
    runBurst(16'hFFF0, 16'h0008, 3, 1'b0, 32'h0, 0, 1'b0);

    for (int i = 0; i < 4; i++) writeWord(16'h0200 + 16'(4 * i), $urandom, 4'hF);
    runBurst(16'h0200, 16'h4, 4, 1'b0, 32'h59, 7, 1'b0);
    runBurst(16'h0200, 16'h4, 3, 1'b0, 32'h0, 1, 1'b1);
    runBurst(16'h0200, 16'h4, 0, 1'b0, 32'h0, 0, 1'b0);
    runBurst(16'h0204, 16'h0, 3, 1'b0, 32'h0, 0, 1'b0);

    // Asynchronous reset after word 1 has been accepted.
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0200, 16'h4, 8'd4, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort valid", 32'(q_valid), 32'd0);
    checkOutput("abort q", q, 32'h0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort last", 32'(q_last), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("abort no done", 32'(done), 32'd0);
    checkOutput("abort stays idle", 32'(busy), 32'd0);
    runBurst(16'h0200, 16'h4, 4, 1'b0, 32'h0, 0, 1'b0);

    // Same-edge write collision and write-ahead visibility.
    writeWord(16'h0300, 32'hA0A1A2A3, 4'hF);
    writeWord(16'h0304, 32'hB0B1B2B3, 4'hF);
    writeWord(16'h0308, 32'hC0C1C2C3, 4'hF);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0300, 16'h4, 8'd3, 1'b1);
    checkOutput("coll w0", q, 32'hA0A1A2A3);
    applyStimulus(1'b1, 16'h0308, 32'h22222222, 4'hF, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0);
    checkOutput("coll stall", q, 32'hA0A1A2A3);
    applyStimulus(1'b1, 16'h0304, 32'h11111111, 4'hF, 1'b0, 16'h0, 16'h0, 8'h0, 1'b1);
    checkOutput("coll old data", q, 32'hB0B1B2B3);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 16'h0, 8'h0, 1'b1);
    checkOutput("coll new ahead", q, 32'h22222222);
    checkOutput("coll last", 32'(q_last), 32'd1);
    tick();
    checkOutput("coll done", 32'(done), 32'd1);
    runBurst(16'h0304, 16'h4, 1, 1'b0, 32'h0, 0, 1'b0);

    // Random bursts inside a preloaded region.
    for (int i = 0; i < 256; i++) writeWord(16'h1000 + 16'(4 * i), $urandom, 4'hF);
    for (int n = 0; n < 25; n++) begin
      logic [15:0] rb;
      logic [15:0] rs;
      int          rl;
      if ($urandom_range(0, 2) == 0)
        writeWord(16'h1000 + 16'($urandom_range(0, 16'h3FC)), $urandom, 4'($urandom_range(0, 15)));
      rb = 16'h1000 + 16'($urandom_range(0, 16'h1FF));
      rs = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h40));
      rl = $urandom_range(0, 6);
      runBurst(rb, rs, rl, 1'b1, 32'h0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
